// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks (h_pos, v_pos) over a full frame and emits
// sync, blanking and line/frame markers aligned to the pixel being presented.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int CNT_W     = 12,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset_ctr_n,
  input  logic               en,
  input  logic               restart,
  output logic [CNT_W-1:0]   h_pos,
  output logic [CNT_W-1:0]   v_pos,
  output logic               hsync,
  output logic               vsync,
  output logic               valid_video,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal active/porch/sync widths must all be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical active/porch/sync widths must all be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON      = (HSYNC_POL != 0);
  localparam logic             VS_ON      = (VSYNC_POL != 0);

  logic               run;
  logic               run_nxt;
  logic [CNT_W-1:0]   h_nxt;
  logic [CNT_W-1:0]   v_nxt;
  logic [FRAME_W-1:0] fc_nxt;

  // The first enabled edge after reset only arms the generator; the raster
  // starts moving on the enabled edges after that.
  always_comb begin
    h_nxt   = h_pos;
    v_nxt   = v_pos;
    fc_nxt  = frame_count;
    run_nxt = run;
    if (restart) begin
      h_nxt   = '0;
      v_nxt   = '0;
      run_nxt = 1'b1;
    end else if (en) begin
      run_nxt = 1'b1;
      if (run) begin
        if (h_pos == H_LAST) begin
          h_nxt = '0;
          if (v_pos == V_LAST) begin
            v_nxt  = '0;
            fc_nxt = frame_count + FRAME_W'(1);
          end else begin
            v_nxt = v_pos + CNT_W'(1);
          end
        end else begin
          h_nxt = h_pos + CNT_W'(1);
        end
      end
    end
  end

  // Flags are decoded from the next position and registered alongside it,
  // so they line up with h_pos/v_pos and come straight out of flops.
  always_ff @(posedge clk or negedge reset_ctr_n) begin
    if (!reset_ctr_n) begin
      h_pos       <= '0;
      v_pos       <= '0;
      frame_count <= '0;
      run         <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      valid_video <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_pos       <= h_nxt;
      v_pos       <= v_nxt;
      frame_count <= fc_nxt;
      run         <= run_nxt;
      hsync       <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_ON : ~HS_ON;
      vsync       <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_ON : ~VS_ON;
      valid_video <= run_nxt && (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
      line_start  <= run_nxt && (h_nxt == '0);
      frame_start <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 15x8 raster; a linear pixel-index model
// supplies expected values for directed vectors and random en/restart traffic.
module tb_vga_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int NPIX = HT * VT;

  logic       clk = 1'b0;
  logic       reset_ctr_n = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] h_pos;
  logic [3:0] v_pos;
  logic       hsync;
  logic       vsync;
  logic       valid_video;
  logic       line_start;
  logic       frame_start;
  logic [1:0] frame_count;

  int n_checks = 0;
  int n_fail = 0;

  int m_pix = 0;
  bit m_run = 1'b0;
  int m_fc = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(1), .CNT_W(4), .FRAME_W(2)
  ) dut (
    .clk(clk), .reset_ctr_n(reset_ctr_n), .en(en), .restart(restart),
    .h_pos(h_pos), .v_pos(v_pos), .hsync(hsync), .vsync(vsync),
    .valid_video(valid_video), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit restart;
    int h;
    int v;
    bit line;
    bit frame;
    int fc;
  } vec_t;

  vec_t vecs[9];

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pix = 0;
    m_run = 1'b0;
    m_fc = 0;
  endtask

  task automatic model_step(input bit e, input bit r);
    if (r) begin
      m_pix = 0;
      m_run = 1'b1;
    end else if (e) begin
      if (m_run) begin
        m_pix = (m_pix + 1) % NPIX;
        if (m_pix == 0) m_fc = (m_fc + 1) % 4;
      end
      m_run = 1'b1;
    end
  endtask

  task automatic check_output(input string tag);
    int h, v;
    h = m_pix % HT;
    v = m_pix / HT;
    check_val({tag, " h_pos"}, int'(h_pos), h);
    check_val({tag, " v_pos"}, int'(v_pos), v);
    check_val({tag, " hsync"}, int'(hsync), (h >= 10 && h < 13) ? 0 : 1);
    check_val({tag, " vsync"}, int'(vsync), (v >= 5 && v < 7) ? 1 : 0);
    check_val({tag, " valid_video"}, int'(valid_video), (m_run && h < 8 && v < 4) ? 1 : 0);
    check_val({tag, " line_start"}, int'(line_start), (m_run && h == 0) ? 1 : 0);
    check_val({tag, " frame_start"}, int'(frame_start), (m_run && m_pix == 0) ? 1 : 0);
    check_val({tag, " frame_count"}, int'(frame_count), m_fc);
  endtask

  task automatic apply_stimulus(input bit e, input bit r);
    en = e;
    restart = r;
    @(posedge clk);
    #1;
    model_step(e, r);
  endtask

  initial begin
    int vcount, hlow;
    int fexp[4];
    vecs[0] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 0};
    vecs[1] = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b0, 6, 0, 1'b0, 1'b0, 0};
    fexp = '{2, 3, 0, 1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset");
    reset_ctr_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].restart);
      check_val($sformatf("vec%0d h_pos", i), int'(h_pos), vecs[i].h);
      check_val($sformatf("vec%0d v_pos", i), int'(v_pos), vecs[i].v);
      check_val($sformatf("vec%0d line_start", i), int'(line_start), int'(vecs[i].line));
      check_val($sformatf("vec%0d frame_start", i), int'(frame_start), int'(vecs[i].frame));
      check_val($sformatf("vec%0d frame_count", i), int'(frame_count), vecs[i].fc);
      check_output($sformatf("vec%0d", i));
    end

    // walk from (6,0) to (6,2), then restart with en low
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output("walk1");
    end
    check_val("at (6,2) h_pos", int'(h_pos), 6);
    check_val("at (6,2) v_pos", int'(v_pos), 2);
    apply_stimulus(1'b0, 1'b1);
    check_val("restart en0 h_pos", int'(h_pos), 0);
    check_val("restart en0 v_pos", int'(v_pos), 0);
    check_val("restart en0 frame_start", int'(frame_start), 1);
    check_val("restart en0 frame_count", int'(frame_count), 0);

    // advance to (9,5) and drop reset between edges
    for (int i = 0; i < 84; i++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output("walk2");
    end
    check_val("pre-reset vsync", int'(vsync), 1);
    en = 1'b0;
    #2;
    reset_ctr_n = 1'b0;
    #1;
    model_reset();
    check_output("async reset");
    #3;
    reset_ctr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0);
      check_output("idle after reset");
    end
    apply_stimulus(1'b1, 1'b0);
    check_val("run edge h_pos", int'(h_pos), 0);
    check_val("run edge frame_start", int'(frame_start), 1);
    check_output("run edge");

    // one full frame with en held high
    vcount = int'(valid_video);
    hlow = (hsync == 1'b0) ? 1 : 0;
    for (int i = 1; i <= NPIX; i++) begin
      apply_stimulus(1'b1, 1'b0);
      check_output("frame");
      if (i < NPIX) begin
        vcount += int'(valid_video);
        hlow += (hsync == 1'b0) ? 1 : 0;
      end
    end
    check_val("valid pixels per frame", vcount, 32);
    check_val("hsync low pixels per frame", hlow, 24);
    check_val("first frame frame_count", int'(frame_count), 1);
    check_val("first frame wrap h_pos", int'(h_pos), 0);
    check_val("first frame wrap v_pos", int'(v_pos), 0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) apply_stimulus(1'b1, 1'b0);
      check_val($sformatf("frame %0d frame_count", f + 2), int'(frame_count), fexp[f]);
    end

    // restart with en high must not touch a nonzero frame_count
    for (int i = 0; i < 36; i++) apply_stimulus(1'b1, 1'b0);
    check_output("before restart en1");
    apply_stimulus(1'b1, 1'b1);
    check_val("restart en1 h_pos", int'(h_pos), 0);
    check_val("restart en1 v_pos", int'(v_pos), 0);
    check_val("restart en1 frame_start", int'(frame_start), 1);
    check_val("restart en1 frame_count", int'(frame_count), 1);

    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      check_output("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
